// File: rtl/pe_pkg.sv
// Shared types for the PE-row feeder: FSM states, the operand tuple and
// the serial-MAC length helper.
package pe_pkg;

  localparam int OP_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SERIAL = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic signed [OP_W-1:0] ifm;
    logic signed [OP_W-1:0] wght;
    logic                   last;
  } operand_t;

  function automatic int nbit(input int idepth);
    return 1 << idepth;
  endfunction

endpackage

// File: rtl/pe_feeder.sv
// Upstream sequencer for the bit-serial PE row: turns accepted operand tuples
// into load strobes, the index sweep and accumulator controls.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int IWIDTH = OP_W,
  parameter int IDEPTH = 3,
  parameter int CWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] in_ifm,
  input  logic signed [IWIDTH-1:0] in_wght,
  input  logic                     in_last,
  output logic [IDEPTH-1:0]        idx,
  output logic                     mac_done,
  output logic                     en_i,
  output logic                     clr_i,
  output logic                     en_w,
  output logic                     clr_w,
  output logic                     en_o,
  output logic                     clr_o,
  output logic signed [IWIDTH-1:0] ifm,
  output logic signed [IWIDTH-1:0] wght,
  output logic [CWIDTH-1:0]        elem_cnt,
  output logic                     busy
);

  localparam int                NB       = nbit(IDEPTH);
  localparam logic [IDEPTH-1:0] IDX_LAST = IDEPTH'(NB - 1);
  localparam logic [CWIDTH-1:0] CNT_MAX  = '1;

  state_t   state;
  operand_t cur;
  logic     accept;

  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // The only window inside a running element is its final serial cycle,
  // which lets the next element load without a bubble.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !flush) begin
      case (state)
        IDLE, WAIT, DONE: in_ready = 1'b1;
        SERIAL:           in_ready = (idx == IDX_LAST) && !cur.last;
        default:          in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;
  assign ifm    = IWIDTH'(cur.ifm);
  assign wght   = IWIDTH'(cur.wght);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      idx      <= '0;
      elem_cnt <= '0;
      en_i     <= 1'b0;
      en_w     <= 1'b0;
      en_o     <= 1'b0;
      clr_i    <= 1'b0;
      clr_w    <= 1'b0;
      clr_o    <= 1'b0;
      mac_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      en_i     <= 1'b0;
      en_w     <= 1'b0;
      clr_i    <= 1'b0;
      clr_w    <= 1'b0;
      clr_o    <= 1'b0;
      mac_done <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        clr_i    <= 1'b1;
        clr_w    <= 1'b1;
        clr_o    <= 1'b1;
        en_o     <= 1'b0;
        idx      <= '0;
        elem_cnt <= '0;
        busy     <= 1'b0;
      end else if (accept) begin
        state <= LOAD;
        cur   <= '{ifm: OP_W'(in_ifm), wght: OP_W'(in_wght), last: in_last};
        en_i  <= 1'b1;
        en_w  <= 1'b1;
        en_o  <= 1'b0;
        idx   <= '0;
        busy  <= 1'b1;
        // Accepting from SERIAL or WAIT continues the current dot product;
        // from IDLE or DONE it starts a fresh one.
        if (state == SERIAL || state == WAIT) begin
          elem_cnt <= sat_inc(elem_cnt);
        end else begin
          clr_o    <= 1'b1;
          elem_cnt <= CWIDTH'(1);
        end
      end else begin
        case (state)
          LOAD: begin
            state <= SERIAL;
            en_o  <= 1'b1;
            idx   <= '0;
          end
          SERIAL: begin
            if (idx == IDX_LAST) begin
              en_o <= 1'b0;
              if (cur.last) begin
                state    <= DONE;
                mac_done <= 1'b1;
                idx      <= '0;
              end else begin
                state <= WAIT;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
          DONE: begin
            state    <= IDLE;
            elem_cnt <= '0;
            busy     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder with a cycle-timeline reference model.
module tb_pe_feeder;

  localparam int NB = 8;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, in_last;
  logic signed [7:0] in_ifm, in_wght, ifm, wght;
  logic [2:0]        idx;
  logic              mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o, busy;
  logic [7:0]        elem_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;
  int n_clr = 0;

  pe_feeder dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ifm(in_ifm), .in_wght(in_wght), .in_last(in_last), .idx(idx),
    .mac_done(mac_done), .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w),
    .en_o(en_o), .clr_o(clr_o), .ifm(ifm), .wght(wght), .elem_cnt(elem_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: every accepted tuple schedules its LOAD, NB serial cycles and
  // (for a last tuple) a DONE cycle; once the schedule drains the feeder sits
  // in WAIT mid-dot-product or IDLE otherwise. Ready means nothing is pending.
  typedef struct packed {
    int idx;
    bit en_i, en_w, en_o, clr_i, clr_w, clr_o, mac_done, busy;
    int elem;
  } rec_t;

  rec_t sched[$];
  rec_t exp_r;
  int   m_ifm, m_wght, m_cnt;
  bit   in_dp, tail_wait, started;

  always @(negedge clk) begin
    bit   ready_m, first;
    rec_t r;
    ready_m = !rst && !flush && (sched.size() == 0);
    if (started) begin
      chk("in_ready", int'(in_ready), int'(ready_m));
      chk("idx", int'(idx), exp_r.idx);
      chk("en_i", int'(en_i), int'(exp_r.en_i));
      chk("en_w", int'(en_w), int'(exp_r.en_w));
      chk("en_o", int'(en_o), int'(exp_r.en_o));
      chk("clr_i", int'(clr_i), int'(exp_r.clr_i));
      chk("clr_w", int'(clr_w), int'(exp_r.clr_w));
      chk("clr_o", int'(clr_o), int'(exp_r.clr_o));
      chk("mac_done", int'(mac_done), int'(exp_r.mac_done));
      chk("busy", int'(busy), int'(exp_r.busy));
      chk("elem_cnt", int'(elem_cnt), exp_r.elem);
      chk("ifm", int'(ifm), m_ifm);
      chk("wght", int'(wght), m_wght);
    end
    if (mac_done) n_done++;
    if (clr_o && en_i) n_clr++;

    if (rst) begin
      sched.delete();
      exp_r = '0; m_ifm = 0; m_wght = 0; m_cnt = 0;
      in_dp = 0; tail_wait = 0; started = 1;
    end else if (flush) begin
      sched.delete();
      exp_r = '0; exp_r.clr_i = 1; exp_r.clr_w = 1; exp_r.clr_o = 1;
      m_cnt = 0; in_dp = 0; tail_wait = 0;
    end else if (in_valid && ready_m) begin
      first  = !in_dp;
      m_cnt  = first ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      in_dp  = !in_last;
      m_ifm  = int'(in_ifm);
      m_wght = int'(in_wght);
      exp_r = '0; exp_r.en_i = 1; exp_r.en_w = 1; exp_r.clr_o = first;
      exp_r.busy = 1; exp_r.elem = m_cnt;
      for (int i = 0; i < NB; i++) begin
        r = '0; r.idx = i; r.en_o = 1; r.busy = 1; r.elem = m_cnt;
        sched.push_back(r);
      end
      if (in_last) begin
        r = '0; r.mac_done = 1; r.busy = 1; r.elem = m_cnt;
        sched.push_back(r);
      end
      tail_wait = !in_last;
    end else if (sched.size() != 0) begin
      exp_r = sched.pop_front();
    end else if (tail_wait) begin
      exp_r = '0; exp_r.idx = NB - 1; exp_r.busy = 1; exp_r.elem = m_cnt;
    end else begin
      m_cnt = 0; exp_r = '0;
    end
  end

  // kind 0: tuple accepted, 1: mac_done, 2: serial cycle with idx == val
  task automatic wait_neg(input int kind, input int val, input string nm);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (kind == 0 && in_valid && in_ready) return;
      if (kind == 1 && mac_done) return;
      if (kind == 2 && en_o && int'(idx) == val) return;
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  // Call just after a rising edge; returns just after the edge that took it.
  task automatic send(input int a, input int b, input bit last, input bit hold,
                      output int t);
    in_ifm = 8'(a); in_wght = 8'(b); in_last = last; in_valid = 1'b1;
    wait_neg(0, 0, "accept");
    t = cyc;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    int ta, tb, tc, td, d0, c0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_ifm = '0; in_wght = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(in_ready), 1);
    @(posedge clk); #1;

    // single tuple, last=1
    send(3, -2, 1'b1, 1'b0, ta);
    @(negedge clk);
    chk("t1_ifm", int'(ifm), 3);
    chk("t1_wght", int'(wght), -2);
    chk("t1_en_i_clr_o", int'(en_i && en_w && clr_o), 1);
    wait_neg(1, 0, "done1");
    chk("lat1", cyc - ta, 10);
    chk("cnt_at_done1", int'(elem_cnt), 1);
    @(negedge clk);
    chk("idle_cnt", int'(elem_cnt), 0);
    chk("idle_busy", int'(busy), 0);
    @(posedge clk); #1;

    // three tuples back to back
    c0 = n_clr;
    send(5, 1, 1'b0, 1'b1, ta);
    send(-4, 7, 1'b0, 1'b1, tb);
    send(127, -128, 1'b1, 1'b0, tc);
    chk("b2b_gap1", tb - ta, 9);
    chk("b2b_gap2", tc - ta, 18);
    wait_neg(1, 0, "done3");
    chk("lat3", cyc - ta, 28);
    chk("cnt_at_done3", int'(elem_cnt), 3);
    chk("clr_o_count3", n_clr - c0, 1);
    @(posedge clk); #1;

    // stall into WAIT
    send(1, 1, 1'b0, 1'b0, ta);
    wait_neg(2, 7, "idx7");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_state", int'(!en_o && idx == 3'd7 && busy), 1);
    end
    @(posedge clk); #1;
    send(2, 2, 1'b1, 1'b0, tb);
    chk("wait_len", tb - ta, 13);
    @(negedge clk);
    chk("wait_load_clr_o", int'(clr_o), 0);
    chk("wait_load_cnt", int'(elem_cnt), 2);
    wait_neg(1, 0, "done_wait");
    @(posedge clk); #1;

    // flush in the middle of the second element
    d0 = n_done;
    send(10, 20, 1'b0, 1'b1, ta);
    send(30, 40, 1'b0, 1'b0, tb);
    wait_neg(2, 2, "idx2");
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_idx", int'(idx), 3);
    chk("flush_cycle_ready", int'(in_ready), 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_clr", int'(clr_i && clr_w && clr_o), 1);
    chk("flush_en_o", int'(en_o), 0);
    chk("flush_cnt", int'(elem_cnt), 0);
    repeat (12) @(negedge clk);
    chk("flush_no_done", n_done - d0, 0);
    @(posedge clk); #1;

    // rst together with flush mid-serial
    send(-1, -1, 1'b1, 1'b0, ta);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_outs", int'(ifm) | int'(wght) | int'(idx) | int'(elem_cnt), 0);
    chk("rst_ctl", int'({en_o, en_i, clr_o, mac_done}), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // new dot product accepted in the DONE cycle
    d0 = n_done;
    send(7, 7, 1'b1, 1'b0, ta);
    wait_neg(2, 6, "idx6");
    @(posedge clk); #1;
    send(9, 9, 1'b1, 1'b0, tb);
    chk("done_accept_time", tb - ta, 10);
    @(negedge clk);
    chk("done_b2b_clr_o", int'(clr_o), 1);
    chk("done_b2b_cnt", int'(elem_cnt), 1);
    chk("done_b2b_pulse", n_done - d0, 1);
    wait_neg(1, 0, "done_b2b");
    chk("lat_b2b", cyc - tb, 10);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
